// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding, defaults and butterfly address helper
package fft_pkg;

    localparam int LOG2N_DEF = 3;
    localparam int TW_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fft_state_e;

    // Returns {addr_a, addr_b, tw_index} for butterfly k of stage s, 8 bits per field.
    function automatic logic [23:0] bf_addr(input logic [7:0] s, input logic [7:0] k,
                                            input logic [7:0] tw_w);
        logic [7:0] half;
        logic [7:0] pos;
        logic [7:0] a;
        half = 8'd1 << s;
        pos  = k & (half - 8'd1);
        a    = ((k >> s) << (s + 8'd1)) | pos;
        return {a, a | half, pos << (tw_w - 8'd1 - s)};
    endfunction

endpackage

// File: rtl/fft_inflight_cnt.sv
// rtl/fft_inflight_cnt.sv - saturating in-flight butterfly counter with sticky underflow flag
module fft_inflight_cnt #(
    parameter int MAX_INFL = 4,
    parameter int CW       = $clog2(MAX_INFL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr_err,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic          err
);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q & ~clr_err;
        if (inc && !dec) begin
            if (count_q != CW'(MAX_INFL)) begin
                count_d = count_q + CW'(1);
            end
        end else if (dec && !inc) begin
            // A retire with nothing outstanding is a datapath protocol error.
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign err       = err_q;

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// rtl/fft_butterfly_scheduler.sv - sequences radix-2 DIT butterflies stage by stage, draining between stages
module fft_butterfly_scheduler
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int TW_W     = TW_W_DEF,
    parameter int MAX_INFL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_index,
    output logic [LOG2N-1:0] stage,
    output logic             bf_last,
    input  logic             wb_valid,
    output logic             err
);

    localparam int                KW     = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int                CW     = $clog2(MAX_INFL + 1);
    localparam logic [KW-1:0]     K_LAST = KW'((1 << (LOG2N - 1)) - 1);
    localparam logic [LOG2N-1:0]  S_LAST = LOG2N'(LOG2N - 1);

    fft_state_e       state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bf_valid_q, bf_valid_d;
    logic             bf_last_q, bf_last_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [TW_W-1:0]  tw_q, tw_d;

    logic             hs;
    logic             clr_err;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LOG2N-1:0] k_ext, half, pos;
    logic [TW_W-1:0]  tw_sh;

    fft_inflight_cnt #(
        .MAX_INFL (MAX_INFL),
        .CW       (CW)
    ) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (hs),
        .dec       (wb_valid),
        .clr_err   (clr_err),
        .count     (cnt_q),
        .count_nxt (cnt_d),
        .err       (err)
    );

    always_comb begin
        hs      = bf_valid_q & bf_ready;
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        clr_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                    clr_err = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (hs) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Next stage reads results of this one, so wait for every retire.
                if (cnt_q == '0) begin
                    k_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                        stage_d = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + LOG2N'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Command fields are computed from the next position so they can be registered.
        k_ext    = LOG2N'(k_d);
        half     = LOG2N'(1) << stage_d;
        pos      = k_ext & (half - LOG2N'(1));
        addr_a_d = ((k_ext >> stage_d) << (stage_d + LOG2N'(1))) | pos;
        addr_b_d = addr_a_d | half;
        tw_sh    = TW_W'(TW_W - 1) - TW_W'(stage_d);
        tw_d     = TW_W'(pos) << tw_sh;

        bf_valid_d = (state_d == ST_ISSUE) && (cnt_d < CW'(MAX_INFL));
        bf_last_d  = (state_d == ST_ISSUE) && (k_d == K_LAST);
        busy_d     = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bf_valid_q <= 1'b0;
            bf_last_q  <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_q       <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bf_valid_q <= bf_valid_d;
            bf_last_q  <= bf_last_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tw_q       <= tw_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bf_valid = bf_valid_q;
    assign bf_last  = bf_last_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign tw_index = tw_q;
    assign stage    = stage_q;

endmodule
